// File: rtl/id_pkg.sv
// Shared types and constants for the decode/operand stage: FSM states,
// instruction register-field positions and default widths.
package id_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int PC_W_DEF    = 32;
  localparam int NUM_FWD_DEF = 3;
  localparam int CNT_W_DEF   = 16;

  localparam int REG_AW = 5;
  localparam int RS_LSB = 21;  // rs = inst[25:21]
  localparam int RT_LSB = 16;  // rt = inst[20:16]

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_HOLD      = 2'd2,
    ST_INTERLOCK = 2'd3
  } id_state_e;

  function automatic logic [REG_AW-1:0] inst_rs(input logic [31:0] inst);
    return inst[RS_LSB +: REG_AW];
  endfunction

  function automatic logic [REG_AW-1:0] inst_rt(input logic [31:0] inst);
    return inst[RT_LSB +: REG_AW];
  endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Per-operand bypass select: the lowest-index writer of the address wins,
// falling back to the regfile; register zero always reads as zero.
module id_fwd_mux
  import id_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int NUM_FWD = NUM_FWD_DEF
) (
  input  logic [REG_AW-1:0]                   addr_i,
  input  logic [DATA_W-1:0]                   rf_rdata_i,
  input  logic [NUM_FWD-1:0]                  fwd_we_i,
  input  logic [NUM_FWD-1:0][REG_AW-1:0]      fwd_waddr_i,
  input  logic [NUM_FWD-1:0][DATA_W-1:0]      fwd_wdata_i,
  input  logic [NUM_FWD-1:0]                  fwd_pending_i,
  output logic [DATA_W-1:0]                   opnd_o,
  output logic                                pending_o
);

  always_comb begin
    opnd_o    = rf_rdata_i;
    pending_o = 1'b0;
    // Walk oldest to youngest so the youngest match is the one left standing.
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_we_i[i] && (fwd_waddr_i[i] == addr_i)) begin
        opnd_o    = fwd_wdata_i[i];
        pending_o = fwd_pending_i[i];
      end
    end
    if (addr_i == '0) begin
      opnd_o    = '0;
      pending_o = 1'b0;
    end
  end

endmodule

// File: rtl/id_operand_stage.sv
// Decode/operand stage: holds one instruction, reads and bypasses its two
// source operands, interlocks on pending results and counts stall cycles.
module id_operand_stage
  import id_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PC_W    = PC_W_DEF,
  parameter int NUM_FWD = NUM_FWD_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           stall_in,
  input  logic                           valid_in,
  input  logic [PC_W-1:0]                pc_in,
  input  logic [31:0]                    inst_in,
  output logic [REG_AW-1:0]              raddr1,
  output logic [REG_AW-1:0]              raddr2,
  input  logic [DATA_W-1:0]              rf_rdata1,
  input  logic [DATA_W-1:0]              rf_rdata2,
  input  logic [NUM_FWD-1:0]             fwd_we,
  input  logic [NUM_FWD-1:0][REG_AW-1:0] fwd_waddr,
  input  logic [NUM_FWD-1:0][DATA_W-1:0] fwd_wdata,
  input  logic [NUM_FWD-1:0]             fwd_pending,
  output logic                           out_valid,
  output logic [PC_W-1:0]                out_pc,
  output logic [31:0]                    out_inst,
  output logic [DATA_W-1:0]              out_opa,
  output logic [DATA_W-1:0]              out_opb,
  output logic                           stallreq,
  output logic [CNT_W-1:0]               stall_cnt
);

  id_state_e         state_q, state_d;
  logic [PC_W-1:0]   id_pc_q, id_pc_d;
  logic [31:0]       inst_hold_q, inst_hold_d;
  logic              inst_held_q, inst_held_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic              id_valid, advance;
  logic [31:0]       inst;
  logic [DATA_W-1:0] opa, opb;
  logic              pend_a, pend_b;

  // The FSM doubles as the valid bit: every non-EMPTY state holds an instruction.
  assign id_valid = (state_q != ST_EMPTY);

  // SRAM data is only valid the cycle after capture, so it is latched on a stall.
  assign inst   = inst_held_q ? inst_hold_q : inst_in;
  assign raddr1 = inst_rs(inst);
  assign raddr2 = inst_rt(inst);

  id_fwd_mux #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD)) u_fwd_a (
    .addr_i        (raddr1),
    .rf_rdata_i    (rf_rdata1),
    .fwd_we_i      (fwd_we),
    .fwd_waddr_i   (fwd_waddr),
    .fwd_wdata_i   (fwd_wdata),
    .fwd_pending_i (fwd_pending),
    .opnd_o        (opa),
    .pending_o     (pend_a)
  );

  id_fwd_mux #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD)) u_fwd_b (
    .addr_i        (raddr2),
    .rf_rdata_i    (rf_rdata2),
    .fwd_we_i      (fwd_we),
    .fwd_waddr_i   (fwd_waddr),
    .fwd_wdata_i   (fwd_wdata),
    .fwd_pending_i (fwd_pending),
    .opnd_o        (opb),
    .pending_o     (pend_b)
  );

  assign stallreq  = ~rst & id_valid & (pend_a | pend_b);
  assign advance   = ~stall_in & ~stallreq;
  assign out_valid = ~rst & id_valid & ~stallreq;

  assign out_pc    = out_valid ? id_pc_q : '0;
  assign out_inst  = out_valid ? inst    : '0;
  assign out_opa   = out_valid ? opa     : '0;
  assign out_opb   = out_valid ? opb     : '0;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    state_d = state_q;
    if (flush)          state_d = ST_EMPTY;
    else if (advance)   state_d = valid_in ? ST_ISSUE : ST_EMPTY;
    else if (!id_valid) state_d = ST_EMPTY;
    else if (stallreq)  state_d = ST_INTERLOCK;
    else                state_d = ST_HOLD;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    id_pc_d     = id_pc_q;
    inst_hold_d = inst_hold_q;
    inst_held_d = inst_held_q;
    if (flush) begin
      inst_held_d = 1'b0;
    end else if (advance) begin
      id_pc_d     = pc_in;
      inst_held_d = 1'b0;
    end else if (id_valid && !inst_held_q) begin
      inst_hold_d = inst_in;
      inst_held_d = 1'b1;
    end
    // Counts regardless of flush; saturates instead of wrapping.
    stall_cnt_d = stall_cnt_q;
    if (stallreq && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_pc_q     <= '0;
      inst_hold_q <= '0;
      inst_held_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      id_pc_q     <= id_pc_d;
      inst_hold_q <= inst_hold_d;
      inst_held_q <= inst_held_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_id_operand_stage.sv
// Randomized bench for id_operand_stage against a transaction-level model of
// the stage, plus directed forwarding/interlock/hold/flush/saturation cases.
module tb_id_operand_stage;

  localparam int DW = 32;
  localparam int PW = 32;
  localparam int NF = 3;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst, flush, stall_in, valid_in;
  logic [PW-1:0]         pc_in;
  logic [31:0]           inst_in;
  logic [4:0]            raddr1, raddr2;
  logic [DW-1:0]         rf_rdata1, rf_rdata2;
  logic [NF-1:0]         fwd_we, fwd_pending;
  logic [NF-1:0][4:0]    fwd_waddr;
  logic [NF-1:0][DW-1:0] fwd_wdata;
  logic                  out_valid, stallreq;
  logic [PW-1:0]         out_pc;
  logic [31:0]           out_inst;
  logic [DW-1:0]         out_opa, out_opb;
  logic [CW-1:0]         stall_cnt;

  id_operand_stage #(.DATA_W(DW), .PC_W(PW), .NUM_FWD(NF), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_in(stall_in),
    .valid_in(valid_in), .pc_in(pc_in), .inst_in(inst_in),
    .raddr1(raddr1), .raddr2(raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .fwd_pending(fwd_pending),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_opa(out_opa), .out_opb(out_opb),
    .stallreq(stallreq), .stall_cnt(stall_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: the instruction sitting in ID, its encoding once known, and the counter.
  bit          m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_enc;
  bit          m_known;
  int          m_cnt;
  logic [31:0] enc;
  bit          e_stall;

  function automatic void ref_op(input logic [4:0] a, input logic [31:0] rf,
                                 output logic [31:0] v, output bit p);
    bit found = 0;
    v = (a == 5'd0) ? 32'd0 : rf;
    p = 0;
    if (a != 5'd0)
      for (int i = 0; i < NF; i++)
        if (!found && fwd_we[i] && fwd_waddr[i] == a) begin
          found = 1;
          v = fwd_wdata[i];
          p = fwd_pending[i];
        end
  endfunction

  task automatic settle();
    logic [31:0] va, vb;
    bit pa, pb, e_valid;
    @(negedge clk);
    enc = m_known ? m_enc : inst_in;
    ref_op(enc[25:21], rf_rdata1, va, pa);
    ref_op(enc[20:16], rf_rdata2, vb, pb);
    e_stall = !rst && m_valid && (pa || pb);
    e_valid = !rst && m_valid && !e_stall;
    chk("stallreq", stallreq, e_stall);
    chk("out_valid", out_valid, e_valid);
    chk("out_pc", out_pc, e_valid ? m_pc : 32'd0);
    chk("out_inst", out_inst, e_valid ? enc : 32'd0);
    chk("out_opa", out_opa, e_valid ? va : 32'd0);
    chk("out_opb", out_opb, e_valid ? vb : 32'd0);
    chk("stall_cnt", stall_cnt, m_cnt);
    if (m_valid && !rst) begin
      chk("raddr1", raddr1, enc[25:21]);
      chk("raddr2", raddr2, enc[20:16]);
    end
  endtask

  task automatic adv();
    if (rst) begin
      m_valid = 0; m_known = 0; m_cnt = 0; m_pc = '0;
    end else begin
      if (e_stall && m_cnt < CNT_MAX) m_cnt++;
      if (flush) begin
        m_valid = 0; m_known = 0;
      end else if (!stall_in && !e_stall) begin
        m_valid = valid_in; m_pc = pc_in; m_known = 0;
      end else if (m_valid) begin
        m_enc = enc; m_known = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; flush = 0; stall_in = 0; valid_in = 0; pc_in = '0; inst_in = '0;
    rf_rdata1 = '0; rf_rdata2 = '0; fwd_we = '0; fwd_pending = '0;
    fwd_waddr = '0; fwd_wdata = '0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; settle(); adv(); rst = 0;
  endtask

  task automatic enter(input logic [31:0] pc);
    idle(); valid_in = 1; pc_in = pc; settle(); adv();
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt);
    return {6'h23, rs, rt, 16'h1234};
  endfunction

  task automatic load_use_on_rs8();
    idle(); inst_in = mk(5'd8, 5'd0); fwd_we = 3'b001; fwd_waddr[0] = 5'd8; fwd_pending = 3'b001;
  endtask

  initial begin
    idle();
    rst = 1;
    m_valid = 0; m_known = 0; m_cnt = 0; m_pc = '0; m_enc = '0;
    repeat (2) @(posedge clk);
    #1;
    settle();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_stallreq", stallreq, 1'b0);
    chk("rst_stall_cnt", stall_cnt, 4'd0);
    adv();

    // Youngest writer wins the bypass.
    do_reset(); enter(32'h100);
    idle(); inst_in = mk(5'd5, 5'd0); rf_rdata1 = 32'h99;
    fwd_we = 3'b011; fwd_waddr[0] = 5'd5; fwd_waddr[1] = 5'd5;
    fwd_wdata[0] = 32'h11; fwd_wdata[1] = 32'h22;
    settle();
    chk("prio_opa", out_opa, 32'h11);
    chk("prio_valid", out_valid, 1'b1);
    adv();

    // Load-use interlock, then issue with the forwarded value.
    do_reset(); enter(32'h200);
    idle(); inst_in = mk(5'd1, 5'd8); fwd_we = 3'b001; fwd_waddr[0] = 5'd8; fwd_pending = 3'b001;
    settle();
    chk("lu_stallreq", stallreq, 1'b1);
    chk("lu_bubble", out_valid, 1'b0);
    adv();
    idle(); inst_in = 32'hDEADBEEF; fwd_we = 3'b001; fwd_waddr[0] = 5'd8; fwd_wdata[0] = 32'hABCD;
    settle();
    chk("lu_cnt", stall_cnt, 4'd1);
    chk("lu_issue", out_valid, 1'b1);
    chk("lu_opb", out_opb, 32'hABCD);
    chk("lu_inst", out_inst, mk(5'd1, 5'd8));
    chk("lu_pc", out_pc, 32'h200);
    adv();

    // Downstream hold keeps the original encoding while SRAM data changes.
    do_reset(); enter(32'h300);
    idle(); inst_in = mk(5'd2, 5'd3); stall_in = 1; settle(); adv();
    for (int k = 0; k < 2; k++) begin
      idle(); inst_in = $urandom; stall_in = 1; settle();
      chk("hold_inst", out_inst, mk(5'd2, 5'd3));
      adv();
    end
    idle(); inst_in = $urandom; settle();
    chk("hold_release_inst", out_inst, mk(5'd2, 5'd3));
    chk("hold_release_valid", out_valid, 1'b1);
    adv();
    idle(); settle();
    chk("hold_after", out_valid, 1'b0);
    adv();

    // Register zero ignores forwarding and never interlocks.
    do_reset(); enter(32'h400);
    idle(); inst_in = mk(5'd0, 5'd0); rf_rdata1 = 32'h5555; rf_rdata2 = 32'h5555;
    fwd_we = 3'b001; fwd_waddr[0] = 5'd0; fwd_wdata[0] = 32'hFFFF_FFFF; fwd_pending = 3'b001;
    settle();
    chk("r0_opa", out_opa, 32'd0);
    chk("r0_opb", out_opb, 32'd0);
    chk("r0_stall", stallreq, 1'b0);
    adv();

    // Flush during interlock: stage empties, the flush cycle is still counted.
    do_reset(); enter(32'h500);
    load_use_on_rs8(); settle(); adv();
    load_use_on_rs8(); flush = 1; settle();
    chk("fl_stallreq", stallreq, 1'b1);
    adv();
    idle(); settle();
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_stallreq_after", stallreq, 1'b0);
    chk("fl_cnt", stall_cnt, 4'd2);
    adv();

    // Counter saturation.
    do_reset(); enter(32'h600);
    for (int k = 0; k < 20; k++) begin
      load_use_on_rs8(); settle(); adv();
    end
    load_use_on_rs8(); settle();
    chk("sat_cnt", stall_cnt, 4'd15);
    adv();
    idle(); settle();
    chk("sat_hold", stall_cnt, 4'd15);
    adv();

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 99) == 0);
      flush      = ($urandom_range(0, 15) == 0);
      stall_in   = ($urandom_range(0, 3) == 0);
      valid_in   = $urandom_range(0, 1);
      pc_in      = $urandom;
      inst_in    = $urandom;
      inst_in[25:21] = 5'($urandom_range(0, 7));
      inst_in[20:16] = 5'($urandom_range(0, 7));
      rf_rdata1  = $urandom;
      rf_rdata2  = $urandom;
      fwd_we     = 3'($urandom);
      for (int i = 0; i < NF; i++) begin
        fwd_waddr[i]   = 5'($urandom_range(0, 7));
        fwd_wdata[i]   = $urandom;
        fwd_pending[i] = ($urandom_range(0, 3) == 0);
      end
      settle();
      adv();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_operand_stage.md
ID_OPERAND_STAGE -- requirements
Module: id_operand_stage

Interface
REQ-001 SHALL have parameter DATA_W, 32, register/operand data width.
REQ-002 SHALL have parameter PC_W, 32, program-counter width.
REQ-003 SHALL have parameter NUM_FWD, 3, number of forwarding sources; index 0 is the youngest (EX), then MEM, then WB.
REQ-004 SHALL have parameter CNT_W, 16, stall-cycle counter width.
REQ-005 SHALL have port clk  in  1  clock, all state updates on the rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port flush  in  1  kill the held instruction; priority over all other inputs except rst.
REQ-008 SHALL have port stall_in  in  1  downstream (EX) cannot accept this cycle.
REQ-009 SHALL have ports valid_in  in  1 and pc_in  in  PC_W, the fetch bundle.
REQ-010 SHALL have port inst_in  in  32  synchronous instruction SRAM data, valid one cycle after pc_in is captured.
REQ-011 SHALL have ports raddr1, raddr2  out  5 each, the regfile read addresses, equal to inst[25:21] and inst[20:16].
REQ-012 SHALL have ports rf_rdata1, rf_rdata2  in  DATA_W each, combinational regfile read data.
REQ-013 SHALL have ports fwd_we  in  NUM_FWD, fwd_waddr  in  5*NUM_FWD, fwd_wdata  in  DATA_W*NUM_FWD, and fwd_pending  in  NUM_FWD (result not yet available, e.g. a load in flight).
REQ-014 SHALL have ports out_valid  out  1, out_pc  out  PC_W, out_inst  out  32, out_opa  out  DATA_W, out_opb  out  DATA_W.
REQ-015 SHALL have ports stallreq  out  1 (hazard interlock) and stall_cnt  out  CNT_W (performance counter).

Function
REQ-016 SHALL hold the stage state id_valid, id_pc, inst_hold and inst_held, with FSM states EMPTY, ISSUE, HOLD and INTERLOCK.
REQ-017 SHALL select the current instruction as inst_hold when inst_held=1, otherwise inst_in.
REQ-018 SHALL forward each operand from the lowest-index source i with fwd_we[i]=1, fwd_waddr[i]=address and address!=0; with no match, the operand SHALL be rf_rdata; address 0 SHALL always yield 0.
REQ-019 SHALL assert stallreq=1 when id_valid=1 and the selected (lowest-index) matching source for either operand has fwd_pending=1; an older non-pending match SHALL NOT override it.
REQ-020 SHALL compute advance = ~stall_in & ~stallreq.
REQ-021 SHALL drive out_valid = id_valid & ~stallreq, so an interlock emits a bubble.
REQ-022 SHALL force out_pc, out_inst, out_opa and out_opb to 0 whenever out_valid=0.
REQ-023 SHALL, on advance, capture id_valid<=valid_in, id_pc<=pc_in and clear inst_held.
REQ-024 SHALL, when not advancing with id_valid=1 and inst_held=0, latch inst_hold<=inst_in and set inst_held=1, then hold every stage register until advance.
REQ-025 SHALL track FSM state as follows: EMPTY when id_valid=0; ISSUE when advancing a valid instruction; HOLD when stall_in=1 and stallreq=0; INTERLOCK when stallreq=1; stallreq has priority over stall_in.
REQ-026 SHALL, on flush, set id_valid=0, inst_held=0 and state EMPTY on the next edge, regardless of stall_in or stallreq.
REQ-027 SHALL increment stall_cnt each cycle with stallreq=1, saturating at 2^CNT_W-1 with no wrap; only rst SHALL clear it.
REQ-028 SHALL, if flush and a hazard occur in the same cycle, let flush win, and SHALL still count that cycle.

Reset
REQ-029 SHALL, on rst, clear id_valid, id_pc, inst_hold, inst_held and stall_cnt and set state EMPTY; out_valid=0 and stallreq=0 SHALL follow in the same cycle.
REQ-030 SHALL, when rst is asserted mid-stall, discard the held instruction with no replay.

Structure
REQ-031 SHALL place the FSM state typedef, the instruction field positions (RS 25:21, RT 20:16) and default widths in the shared package id_pkg.
REQ-032 SHALL implement the per-operand priority selection as sub-module id_fwd_mux, instantiated twice.

Verification
REQ-033 SHALL cover forwarding priority: fwd 0 and 1 both write r5 (0x11, 0x22), inst reads rs=r5 -> out_opa=0x11.
REQ-034 SHALL cover load-use: fwd_pending[0]=1 on r8, inst reads rt=r8 -> stallreq=1, out_valid=0, stall_cnt+1; pending drops -> issue with the forwarded value.
REQ-035 SHALL cover downstream hold: stall_in=1 for 3 cycles while inst_in changes -> out_inst keeps the original encoding and advances once stall_in=0.
REQ-036 SHALL cover register zero: write to r0 with data 0xFFFF_FFFF from fwd 0, inst reads r0 -> operand 0, no stall.
REQ-037 SHALL cover flush during interlock: flush while stallreq=1 -> next cycle id_valid=0 and state EMPTY, while stall_cnt keeps its count.
REQ-038 SHALL cover counter saturation: CNT_W=4 with 20 hazard cycles -> stall_cnt=15.
